// File: rtl/ivl_uvm_ovl_clk_ctrl.sv
// Clock-enable controller: divides clk into one-cycle enable pulses,
// running continuously until stopped or for a fixed burst of pulses.
module ivl_uvm_ovl_clk_ctrl #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic [CNT_W-1:0] burst_len,
    output logic             clk_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_last;
    logic             mode_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] pulse_nxt;
    logic             zero_burst;
    logic             last_pulse;
    logic             div_hit;

    // A captured ratio of 0 behaves as 1, so the wrap point is 0 in both cases.
    assign div_last   = (div_q == '0) ? '0 : div_q - DIV_W'(1);
    assign div_hit    = (div_cnt == div_last);
    // Zero-length burst: one empty RUN cycle, no enable pulse.
    assign zero_burst = mode_q && (len_q == '0);
    assign pulse_nxt  = pulse_cnt + CNT_W'(1);
    assign last_pulse = mode_q && (pulse_nxt == len_q);

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign clk_en = (state == RUN) && div_hit && !zero_burst;

    // Run-control FSM with configuration capture and pulse counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            pulse_cnt <= '0;
            mode_q    <= 1'b0;
            div_q     <= '0;
            len_q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state     <= RUN;
                        mode_q    <= mode;
                        div_q     <= div_ratio;
                        len_q     <= burst_len;
                        div_cnt   <= '0;
                        pulse_cnt <= '0;
                    end
                end
                RUN: begin
                    div_cnt <= div_hit ? '0 : div_cnt + DIV_W'(1);
                    if (clk_en) begin
                        pulse_cnt <= pulse_nxt;
                    end
                    if (stop || zero_burst || (clk_en && last_pulse)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
